// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch bus: request/grant on the way out, in-order read
// data on the way back. The fetch unit is the master and memory is the slave.
interface pc_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, issues in-order word fetches,
// buffers returned words and presents them to the IF/ID register.
module pc_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_flag_ex_i,
  input  logic [31:0]       jump_addr_ex_i,
  input  logic              hold_flag_ex_i,
  pc_fetch_if.master        mem,
  output logic              inst_valid_o,
  output logic [31:0]       inst_o,
  output logic [31:0]       inst_addr_o
);

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam int          CW       = AW + 1;
  localparam int          DW       = CW + 6;
  localparam logic [CW:0] CREDIT   = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   pc;
  logic [31:0]   aq_mem    [FIFO_DEPTH];
  logic [31:0]   fifo_addr [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [AW-1:0] aq_wr, aq_rd, f_wr, f_rd;
  logic [CW-1:0] f_count, outstanding;
  logic [DW-1:0] discard, inflight, discard_after_jump;
  logic          grant, keep, drop, pop;

  // Credit counts buffered words plus words still in flight, so every
  // granted fetch is guaranteed a FIFO slot when its data returns.
  assign mem.req  = !rst && !jump_flag_ex_i &&
                    (({1'b0, f_count} + {1'b0, outstanding}) < CREDIT);
  assign mem.addr = pc;

  always_comb begin
    grant        = mem.req && mem.gnt;
    drop         = mem.rvalid && (discard != '0);
    keep         = mem.rvalid && (discard == '0) && (outstanding != '0);
    inst_valid_o = (f_count != '0);
    pop          = inst_valid_o && !hold_flag_ex_i && !jump_flag_ex_i;
    inflight     = discard + DW'(outstanding);
    discard_after_jump = inflight;
    // A response landing in the jump cycle is itself one of the words to drop.
    if (mem.rvalid && (inflight != '0)) begin
      discard_after_jump = inflight - DW'(1);
    end
    inst_o      = INST_NOP;
    inst_addr_o = 32'h0;
    if (inst_valid_o) begin
      inst_o      = fifo_data[f_rd];
      inst_addr_o = fifo_addr[f_rd];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      aq_wr       <= '0;
      aq_rd       <= '0;
      f_wr        <= '0;
      f_rd        <= '0;
      f_count     <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (jump_flag_ex_i) begin
      pc          <= jump_addr_ex_i & ~32'h3;
      aq_wr       <= '0;
      aq_rd       <= '0;
      f_wr        <= '0;
      f_rd        <= '0;
      f_count     <= '0;
      outstanding <= '0;
      discard     <= discard_after_jump;
    end else begin
      if (grant) begin
        pc    <= pc + 32'd4;
        aq_wr <= aq_wr + AW'(1);
      end
      if (keep) begin
        f_wr  <= f_wr + AW'(1);
        aq_rd <= aq_rd + AW'(1);
      end
      if (pop) begin
        f_rd <= f_rd + AW'(1);
      end
      f_count     <= f_count + CW'(keep) - CW'(pop);
      outstanding <= outstanding + CW'(grant) - CW'(keep);
      discard     <= discard - DW'(drop);
    end
  end

  // Storage needs no reset; the pointers and counts above decide validity.
  always_ff @(posedge clk) begin
    if (grant) begin
      aq_mem[aq_wr] <= pc;
    end
    if (keep) begin
      fifo_addr[f_wr] <= aq_mem[aq_rd];
      fifo_data[f_wr] <= mem.rdata;
    end
  end

endmodule
